// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system ID (word 0) and build timestamp (word 1)
// and reports pass/fail/timeout. Optional periodic re-check: `define SYSID_PERIODIC_RECHECK_EN.
module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1453155395,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
    parameter bit          START_ON_RESET = 1'b1
`ifdef SYSID_PERIODIC_RECHECK_EN
    ,
    parameter logic [31:0] RECHECK_PERIOD = 32'd50000000
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
`ifdef SYSID_PERIODIC_RECHECK_EN
    ,
    output logic        ever_failed
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_ID = 3'd1,
        ST_RD_TS = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        terr_q, terr_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic        busy_q, busy_d;
    logic        to_hit_s;
    logic        go_s;

`ifdef SYSID_PERIODIC_RECHECK_EN
    logic [31:0] idle_q, idle_d;
    logic        ever_failed_q, ever_failed_d;
`endif

    // Next-state, capture and output-register decode for the check sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        ts_d    = ts_q;
        done_d  = done_q;
        pass_d  = pass_q;
        terr_d  = terr_q;
        // A start seen while a check is running is dropped, never queued.
        start_d = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        to_hit_s = (TIMEOUT_CYCLES != 16'd0) && avm_waitrequest &&
                   (cnt_q == (TIMEOUT_CYCLES - 16'd1));
`ifdef SYSID_PERIODIC_RECHECK_EN
        go_s = start_q || (idle_q == (RECHECK_PERIOD - 32'd1));
`else
        go_s = start_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start_q) begin
                    state_d = ST_RD_ID;
                    cnt_d   = 16'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ID: begin
                if (!avm_waitrequest) begin
                    id_d    = avm_readdata;
                    cnt_d   = 16'd0;
                    state_d = ST_RD_TS;
                end else if (to_hit_s) begin
                    terr_d  = 1'b1;
                    pass_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_RD_TS: begin
                if (!avm_waitrequest) begin
                    ts_d    = avm_readdata;
                    cnt_d   = 16'd0;
                    state_d = ST_CHECK;
                end else if (to_hit_s) begin
                    terr_d  = 1'b1;
                    pass_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            ST_CHECK: begin
                pass_d  = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (go_s) begin
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    terr_d  = 1'b0;
                    cnt_d   = 16'd0;
                    state_d = ST_RD_ID;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus strobes are registered from the next state so they stay glitch-free.
        read_d = (state_d == ST_RD_ID) || (state_d == ST_RD_TS);
        addr_d = (state_d == ST_RD_TS);
        busy_d = (state_d == ST_RD_ID) || (state_d == ST_RD_TS) || (state_d == ST_CHECK);
    end

    // State and result registers; the async clear drops avm_read immediately mid-transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            start_q <= START_ON_RESET;
            cnt_q   <= 16'd0;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            terr_q  <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            terr_q  <= terr_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef SYSID_PERIODIC_RECHECK_EN
    // Idle timer runs only while parked in DONE; any restart zeroes it.
    always_comb begin
        if ((state_q == ST_DONE) && !go_s) begin
            idle_d = idle_q + 32'd1;
        end else begin
            idle_d = 32'd0;
        end
        ever_failed_d = ever_failed_q || (done_d && !pass_d);
    end

    // Re-check timer and sticky failure flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            idle_q        <= 32'd0;
            ever_failed_q <= 1'b0;
        end else begin
            idle_q        <= idle_d;
            ever_failed_q <= ever_failed_d;
        end
    end

    assign ever_failed = ever_failed_q;
`endif

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout_err = terr_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_reader.sv
// Self-checking bench for sysid_reader: wait-state programmable sysid slave, vector table,
// hand-written corner sequences and randomized checks against a latency/result model.
module tb_sysid_reader;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1453155395;
    localparam int          TMO    = 4;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        busy, done, pass, timeout_err;
    logic [31:0] id_value, ts_value;
`ifdef SYSID_PERIODIC_RECHECK_EN
    logic        ever_failed;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    sysid_reader #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (16'd4),
        .START_ON_RESET (1'b1)
`ifdef SYSID_PERIODIC_RECHECK_EN
        ,
        .RECHECK_PERIOD (32'd20)
`endif
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .start           (start),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .timeout_err     (timeout_err),
        .id_value        (id_value),
        .ts_value        (ts_value)
`ifdef SYSID_PERIODIC_RECHECK_EN
        ,
        .ever_failed     (ever_failed)
`endif
    );

    // Sysid slave: each read stalls slv_wait[addr] cycles, garbage data while stalled.
    logic [31:0] slv_mem [2];
    int          slv_wait [2];
    int          wcnt = 0;

    always_comb begin
        avm_waitrequest = avm_read && (wcnt < slv_wait[avm_address]);
        avm_readdata    = avm_waitrequest ? 32'hDEAD_BEEF : slv_mem[avm_address];
    end

    always @(posedge clock) wcnt <= (avm_read && avm_waitrequest) ? wcnt + 1 : 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Address/read must hold while the slave stalls (timeout and reset excepted).
    logic prev_stall = 1'b0;
    logic prev_addr  = 1'b0;
    always @(negedge clock) begin
        if (reset_n && prev_stall && !timeout_err)
            chk("rd_stable", {62'd0, avm_read, avm_address}, {62'd0, 1'b1, prev_addr});
        prev_stall = reset_n && avm_read && avm_waitrequest;
        prev_addr  = avm_address;
    end

    task automatic wait_done(input int bound, output int lat);
        lat = -1;
        for (int k = 1; k <= bound && lat < 0; k++) begin
            @(posedge clock); #1;
            if (done) lat = k;
        end
        if (lat < 0) begin
            n_checks++;
            $display("FAIL wait_done: done not seen, expected within %0d cycles", bound);
        end
    endtask

    task automatic wait_busy(input int bound, output int lat);
        lat = -1;
        for (int k = 1; k <= bound && lat < 0; k++) begin
            @(posedge clock); #1;
            if (busy) lat = k;
        end
    endtask

    task automatic run_check(input int wi, input int wt, output int lat);
        slv_wait[0] = wi;
        slv_wait[1] = wt;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        wait_done(80, lat);
    endtask

    // Reference model: outcome and cycles-after-start from the wait counts alone.
    logic [31:0] m_id, m_ts;
    task automatic model(input logic [31:0] id, input logic [31:0] ts, input int wi, input int wt,
                         output bit p, output bit to, output int lat);
        if (wi >= TMO) begin
            to = 1'b1; p = 1'b0; lat = 1 + TMO;
        end else begin
            m_id = id;
            if (wt >= TMO) begin
                to = 1'b1; p = 1'b0; lat = 2 + wi + TMO;
            end else begin
                m_ts = ts;
                to = 1'b0; lat = 4 + wi + wt;
                p = (m_id == EXP_ID) && (m_ts == EXP_TS);
            end
        end
    endtask

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        int          wi;
        int          wt;
        bit          p;
        bit          to;
        int          lat;
        logic [31:0] eid;
        logic [31:0] ets;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int lat;
        bit mp, mto;
        int mlat;
        logic [31:0] rid, rts;
        int rwi, rwt;

        tbl[0] = '{32'd0, EXP_TS, 0, 0, 1'b1, 1'b0, 4, 32'd0, EXP_TS};
        tbl[1] = '{32'd1, EXP_TS, 0, 0, 1'b0, 1'b0, 4, 32'd1, EXP_TS};
        tbl[2] = '{32'd0, EXP_TS, 3, 3, 1'b1, 1'b0, 10, 32'd0, EXP_TS};
        tbl[3] = '{32'd0, 32'd5, 0, 0, 1'b0, 1'b0, 4, 32'd0, 32'd5};
        tbl[4] = '{32'd7, EXP_TS, 9, 0, 1'b0, 1'b1, 5, 32'd0, 32'd5};
        tbl[5] = '{32'hFFFF_FFFF, EXP_TS, 1, 4, 1'b0, 1'b1, 7, 32'hFFFF_FFFF, 32'd5};
        tbl[6] = '{32'd0, EXP_TS, 2, 1, 1'b1, 1'b0, 7, 32'd0, EXP_TS};
        tbl[7] = '{32'd0, EXP_TS, 0, 3, 1'b1, 1'b0, 7, 32'd0, EXP_TS};
        tbl[8] = '{32'd0, 32'd1453155396, 0, 0, 1'b0, 1'b0, 4, 32'd0, 32'd1453155396};
        tbl[9] = '{32'd0, EXP_TS, 3, 0, 1'b1, 1'b0, 7, 32'd0, EXP_TS};

        slv_mem[0] = EXP_ID; slv_mem[1] = EXP_TS;
        slv_wait[0] = 0;     slv_wait[1] = 0;

        // Reset, then the automatic post-reset check with a zero-wait slave.
        #2 reset_n = 1'b0;
        #10;
        chk("reset_outs", {26'd0, avm_read, avm_address, busy, done, pass, timeout_err,
                           id_value, ts_value}, 64'd0);
        @(negedge clock); reset_n = 1'b1;
        @(posedge clock); #1;
        chk("t1_rd_id", {61'd0, avm_read, avm_address, busy}, {61'd0, 3'b101});
        @(posedge clock); #1;
        chk("t1_rd_ts", {61'd0, avm_read, avm_address, busy}, {61'd0, 3'b111});
        @(posedge clock); #1;
        chk("t1_check", {61'd0, avm_read, busy, done}, {61'd0, 3'b010});
        @(posedge clock); #1;
        chk("t1_done", {60'd0, done, pass, timeout_err, busy}, {60'd0, 4'b1100});
        chk("t1_id", {32'd0, id_value}, {32'd0, EXP_ID});
        chk("t1_ts", {32'd0, ts_value}, {32'd0, EXP_TS});

`ifdef SYSID_PERIODIC_RECHECK_EN
        chk("t6_ef_init", {63'd0, ever_failed}, 64'd0);
        slv_mem[1] = 32'd5;
        wait_busy(40, lat);
        chk("t6_recheck_delay", lat, 20);
        wait_done(40, lat);
        chk("t6_fail", {62'd0, pass, ever_failed}, {62'd0, 2'b01});
        slv_mem[1] = EXP_TS;
        wait_busy(40, lat);
        wait_done(40, lat);
        chk("t6_restored", {62'd0, pass, ever_failed}, {62'd0, 2'b11});
`endif

        // Vector table: results, captured words and start-to-done latency.
        for (int i = 0; i < 10; i++) begin
            slv_mem[0] = tbl[i].id;
            slv_mem[1] = tbl[i].ts;
            run_check(tbl[i].wi, tbl[i].wt, lat);
            chk($sformatf("tbl%0d_lat", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_flags", i), {62'd0, pass, timeout_err},
                {62'd0, tbl[i].p, tbl[i].to});
            chk($sformatf("tbl%0d_id", i), {32'd0, id_value}, {32'd0, tbl[i].eid});
            chk($sformatf("tbl%0d_ts", i), {32'd0, ts_value}, {32'd0, tbl[i].ets});
        end

        // start during RD_TS is ignored; then reset in the middle of RD_ID.
        slv_mem[0] = EXP_ID; slv_mem[1] = EXP_TS;
        slv_wait[0] = 0; slv_wait[1] = 2;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("t5_in_rd_ts", {62'd0, avm_read, avm_address}, {62'd0, 2'b11});
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("t5_done", {62'd0, done, pass}, {62'd0, 2'b11});
        repeat (4) @(posedge clock);
        #1;
        chk("t5_no_restart", {62'd0, busy, done}, {62'd0, 2'b01});

        slv_wait[0] = 1000; slv_wait[1] = 0;
        @(negedge clock); start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        @(posedge clock); #1;
        chk("t5_mid_rd_id", {62'd0, avm_read, busy}, {62'd0, 2'b11});
        #2 reset_n = 1'b0;
        #1;
        chk("t5_async_read", {63'd0, avm_read}, 64'd0);
        chk("t5_async_outs", {26'd0, avm_read, avm_address, busy, done, pass, timeout_err,
                              id_value, ts_value}, 64'd0);
        slv_wait[0] = 0;
        @(negedge clock); reset_n = 1'b1;
        wait_done(20, lat);
        chk("t5_autostart_lat", lat, 4);
        chk("t5_autostart_pass", {63'd0, pass}, 64'd1);
        m_id = EXP_ID;
        m_ts = EXP_TS;

        // Randomized checks against the model.
        for (int i = 0; i < 30; i++) begin
            rid = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
            rts = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
            rwi = $urandom_range(0, 5);
            rwt = $urandom_range(0, 5);
            slv_mem[0] = rid;
            slv_mem[1] = rts;
            model(rid, rts, rwi, rwt, mp, mto, mlat);
            run_check(rwi, rwt, lat);
            chk($sformatf("rnd%0d_lat", i), lat, mlat);
            chk($sformatf("rnd%0d_flags", i), {62'd0, pass, timeout_err}, {62'd0, mp, mto});
            chk($sformatf("rnd%0d_id", i), {32'd0, id_value}, {32'd0, m_id});
            chk($sformatf("rnd%0d_ts", i), {32'd0, ts_value}, {32'd0, m_ts});
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
